sp_match_scheduler: RTL and testbench

SP_MATCH_SCHEDULER -- requirements
Module: sp_match_scheduler

---
 rtl/sp_match_scheduler.sv | 162 ++++++++++++++++
 tb/tb_sp_match_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_match_scheduler.sv
// sp_match_scheduler: round-robin front end for a shared source-port range
// match tree. Granted port IDs go into the tree. A tag pipeline of the same
// depth follows each issue. Qualified tree results go into a fall-through
// result FIFO. A credit counter limits issues in flight plus buffered results
// to the FIFO depth.
// Optional statistics counters are built only when SP_SCHED_STATS_EN is defined.
module sp_match_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int TREE_LATENCY = 6,
    parameter int RSP_DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [16*NUM_REQ-1:0]      req_port,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [16:0]                tree_in,
    input  logic [31:0]                tree_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [31:0]                rsp_rule_set
`ifdef SP_SCHED_STATS_EN
    ,
    output logic [31:0]                stat_issued,
    output logic [31:0]                stat_stall
`endif
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int PTR_W   = $clog2(RSP_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ID_W + 32;

    logic [ID_W-1:0]    last_gnt_reg;
    logic [CNT_W-1:0]   credit_reg;
    logic               grant;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    cand;

    logic               tag_valid_reg [TREE_LATENCY];
    logic [ID_W-1:0]    tag_id_reg    [TREE_LATENCY];

    logic [ENTRY_W-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;

    // Round-robin search starting just after the last granted requester.
    // No search happens without credit.
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (credit_reg != '0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = ID_W'((int'(last_gnt_reg) + k) % NUM_REQ);
                if (!grant && req[cand]) begin
                    grant   = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        gnt = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

    // The granted port goes to the tree in the grant cycle itself.
    assign tree_in = grant ? {1'b1, req_port[{gnt_idx, 4'b0000} +: 16]} : 17'h0;

    // Remember the last grant. Reset points at the top index so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset)
            last_gnt_reg <= ID_W'(NUM_REQ - 1);
        else if (grant)
            last_gnt_reg <= gnt_idx;
    end

    // Credit counts FIFO slots not yet claimed by an issue. A grant and a pop in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset)
            credit_reg <= CNT_W'(RSP_DEPTH);
        else if (grant && !pop)
            credit_reg <= credit_reg - 1'b1;
        else if (pop && !grant)
            credit_reg <= credit_reg + 1'b1;
    end

    // Tag shift register. It matches the tree latency, so the last stage lines up with tree_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TREE_LATENCY; i++) begin
                tag_valid_reg[i] <= 1'b0;
                tag_id_reg[i]    <= '0;
            end
        end else begin
            tag_valid_reg[0] <= grant;
            tag_id_reg[0]    <= gnt_idx;
            for (int i = 1; i < TREE_LATENCY; i++) begin
                tag_valid_reg[i] <= tag_valid_reg[i-1];
                tag_id_reg[i]    <= tag_id_reg[i-1];
            end
        end
    end

    assign push       = tag_valid_reg[TREE_LATENCY-1];
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(RSP_DEPTH));
    assign pop        = rsp_valid && rsp_ready;

    // Result storage, with no reset. The head read is asynchronous so the FIFO can fall through.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {tag_id_reg[TREE_LATENCY-1], tree_out};
    end

    // FIFO pointers and occupancy. A push and a pop in the same cycle both take effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head outputs are forced to zero while the FIFO is empty, so memory left over from before reset never shows.
    assign rsp_valid = !fifo_empty;
    assign {rsp_id, rsp_rule_set} = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];

    // The credit scheme guarantees that a push never meets a full FIFO unless a pop happens in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full && !pop));

`ifdef SP_SCHED_STATS_EN
    // Statistics: issued grants, and cycles where requests were blocked only by lack of credit.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant)
                stat_issued <= stat_issued + 32'd1;
            if ((|req) && (credit_reg == '0))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sp_match_scheduler.sv
// Directed bench for sp_match_scheduler. A 6-cycle tree model returns fixed rule sets.
// A monitor compares every accepted result against a queue of hand-computed entries.
// Define SP_SCHED_STATS_EN to build and check the statistics outputs.
module tb_sp_match_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_port;
    logic [3:0]  gnt;
    logic [16:0] tree_in;
    logic [31:0] tree_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_rule_set;
`ifdef SP_SCHED_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
`endif

    int errors = 0;
    int checks = 0;
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;
    logic [16:0] tpipe [6];

    logic [31:0] rules4 [4] = '{32'h00008BCF, 32'h0000000D, 32'h00000ADE, 32'h000000AE};
    logic [15:0] ports4 [4] = '{16'd300, 16'd30000, 16'd50000, 16'd65535};

    always #5 clk = ~clk;

    sp_match_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_port     (req_port),
        .gnt          (gnt),
        .tree_in      (tree_in),
        .tree_out     (tree_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_rule_set (rsp_rule_set)
`ifdef SP_SCHED_STATS_EN
        ,
        .stat_issued  (stat_issued),
        .stat_stall   (stat_stall)
`endif
    );

    function automatic logic [31:0] rules_of(input logic [15:0] port);
        case (port)
            16'd80:    return 32'h000008BF;
            16'd300:   return 32'h00008BCF;
            16'd30000: return 32'h0000000D;
            16'd50000: return 32'h00000ADE;
            16'd65535: return 32'h000000AE;
            default:   return 32'h12345670 ^ {16'h0, port};
        endcase
    endfunction

    // Match tree model with six cycles of latency. Unqualified output is junk.
    always @(posedge clk) begin
        tpipe[0] <= tree_in;
        for (int i = 1; i < 6; i++) tpipe[i] <= tpipe[i-1];
    end
    assign tree_out = tpipe[5][16] ? rules_of(tpipe[5][15:0]) : 32'hDEADBEEF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare every accepted result, in order.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_extra", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(mon_e[33:32]));
                check("rsp_rule", 64'(rsp_rule_set), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        req = 4'b0;
        repeat (n) next_cycle();
    endtask

    initial begin
        int n;
        logic [3:0] one;
        one       = 4'b0001;
        reset     = 1'b1;
        req       = 4'b0;
        req_port  = 64'h0;
        rsp_ready = 1'b0;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_tree_in", 64'(tree_in), 64'(0));
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_id", 64'(rsp_id), 64'(0));
        check("rst_rule", 64'(rsp_rule_set), 64'(0));

        // Single request, port 80. The result appears 7 cycles after the grant.
        do_reset();
        rsp_ready      = 1'b1;
        req_port[15:0] = 16'd80;
        req            = 4'b0001;
        @(negedge clk);
        check("t1_gnt", 64'(gnt), 64'(4'b0001));
        check("t1_tree_in", 64'(tree_in), 64'(17'h10050));
        exp_q.push_back({2'd0, 32'h000008BF});
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            req = 4'b0;
            @(negedge clk);
            if (k == 1) check("t1_tree_idle", 64'(tree_in), 64'(0));
            if (k == 7) check("t1_valid_at7", 64'(rsp_valid), 64'(1));
            else        check("t1_valid_off", 64'(rsp_valid), 64'(0));
        end
        check("t1_drained", 64'(exp_q.size()), 64'(0));

        // All four requesters active. Grants go 0,1,2,3,0... and results come back in order.
        do_reset();
        rsp_ready = 1'b1;
        req_port  = {ports4[3], ports4[2], ports4[1], ports4[0]};
        req       = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            check("t2_gnt", 64'(gnt), 64'(one << (k % 4)));
            check("t2_tree_in", 64'(tree_in), 64'({1'b1, ports4[k % 4]}));
            exp_q.push_back({2'(k % 4), rules4[k % 4]});
        end
        next_cycle();
        drain(16);
        check("t2_drained", 64'(exp_q.size()), 64'(0));

        // Only requester 2 is active after requester 3 was last granted. The search wraps and grants it at once.
        req = 4'b0100;
        @(negedge clk);
        check("t4_wrap_gnt", 64'(gnt), 64'(4'b0100));
        exp_q.push_back({2'd2, 32'h00000ADE});
        next_cycle();
        drain(12);
        check("t4_drained", 64'(exp_q.size()), 64'(0));

        // Backpressure: exactly 8 grants, then a stall. Releasing it gives one grant per pop.
        do_reset();
        rsp_ready = 1'b0;
        req       = 4'b1111;
        n         = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            if (k < 8) begin
                check("t3_gnt", 64'(gnt), 64'(one << (k % 4)));
                exp_q.push_back({2'(k % 4), rules4[k % 4]});
                n++;
            end else begin
                check("t3_stall", 64'(gnt), 64'(0));
            end
        end
        check("t3_head_valid", 64'(rsp_valid), 64'(1));
        check("t3_head_id", 64'(rsp_id), 64'(0));
        check("t3_head_rule", 64'(rsp_rule_set), 64'(32'h00008BCF));
        for (int k = 0; k < 30; k++) begin
            next_cycle();
            rsp_ready = 1'b1;
            @(negedge clk);
`ifdef SP_SCHED_STATS_EN
            if (k == 0) begin
                check("stat_issued", 64'(stat_issued), 64'(8));
                check("stat_stall", 64'(stat_stall), 64'(12));
            end
`endif
            if (k == 0) check("t3_no_gnt_before_pop", 64'(gnt), 64'(0));
            if (k == 1) check("t3_gnt_after_pop", 64'(gnt), 64'(4'b0001));
            if (gnt != 4'b0) begin
                check("t3_rr", 64'(gnt), 64'(one << (n % 4)));
                exp_q.push_back({2'(n % 4), rules4[n % 4]});
                n++;
            end
        end
        next_cycle();
        drain(16);
        check("t3_drained", 64'(exp_q.size()), 64'(0));

        // Reset with 5 issues in flight: all of them are discarded and full credit returns.
        do_reset();
        rsp_ready = 1'b1;
        req       = 4'b1111;
        repeat (5) next_cycle();
        req = 4'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("t5_no_stale_valid", 64'(rsp_valid), 64'(0));
            next_cycle();
        end
        rsp_ready      = 1'b0;
        req_port[15:0] = 16'd80;
        req            = 4'b0001;
        n              = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (gnt != 4'b0) begin
                n++;
                exp_q.push_back({2'd0, 32'h000008BF});
            end
            next_cycle();
        end
        check("t5_credit_grants", 64'(n), 64'(8));
        @(negedge clk);
        check("t5_new_valid", 64'(rsp_valid), 64'(1));
        next_cycle();
        rsp_ready = 1'b1;
        drain(20);
        check("t5_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
